// File: rtl/player_motion_if.sv
// Bundles the frame strobe, key levels and collision flags going into the
// player motion block, together with the position and state coming back out.
interface player_motion_if;
  // tick is a one-clk strobe with no backpressure. Inputs are sampled on the clk
  // edge where tick=1, and the outputs show the result one clk after that edge.
  logic       tick;
  logic       key_left;
  logic       key_right;
  logic       key_jump;
  logic [3:0] coll;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic [1:0] v_state;
  logic       on_ground;

  modport master (
    output tick, key_left, key_right, key_jump, coll,
    input  x_blue, y_blue, v_state, on_ground
  );

  modport slave (
    input  tick, key_left, key_right, key_jump, coll,
    output x_blue, y_blue, v_state, on_ground
  );
endinterface

// File: rtl/player_motion.sv
// Blue player position: one-pixel-per-tick horizontal walking, plus a vertical
// STAND/RISE/FALL machine driven by collision flags and an edge-captured jump key.
module player_motion #(
  parameter logic [9:0] X_INIT = 10'd40,
  parameter logic [8:0] Y_INIT = 9'd400,
  parameter logic [9:0] X_MAX  = 10'd617,
  parameter logic [8:0] Y_MAX  = 9'd435,
  parameter logic [6:0] JUMP_H = 7'd60
) (
  input  logic           clk,
  input  logic           rst_n,
  player_motion_if.slave bus
);

  typedef enum logic [1:0] {
    ST_STAND = 2'd0,
    ST_RISE  = 2'd1,
    ST_FALL  = 2'd2
  } vstate_e;

  vstate_e    state_q;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q;
  logic [6:0] rise_cnt_q;
  logic       jump_req_q;
  logic       jump_prev_q;
  logic       on_ground_q;
  logic       jump_rise;

  assign jump_rise = bus.key_jump & ~jump_prev_q;

  // Bounds are checked before stepping, so x cannot wrap past 0 or X_MAX.
  always_comb begin
    x_d = x_q;
    if (bus.key_right && !bus.key_left && !bus.coll[2] && (x_q < X_MAX))
      x_d = x_q + 10'd1;
    else if (bus.key_left && !bus.key_right && !bus.coll[3] && (x_q != 10'd0))
      x_d = x_q - 10'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FALL;
      x_q         <= X_INIT;
      y_q         <= Y_INIT;
      rise_cnt_q  <= 7'd0;
      jump_req_q  <= 1'b0;
      jump_prev_q <= 1'b0;
      on_ground_q <= 1'b0;
    end else begin
      jump_prev_q <= bus.key_jump;
      if (bus.tick) begin
        // A pending jump is consumed or dropped on every tick: no buffering.
        jump_req_q <= 1'b0;
        x_q        <= x_d;
        case (state_q)
          ST_STAND: begin
            if (!bus.coll[0] && (y_q < Y_MAX)) begin
              state_q     <= ST_FALL;
              on_ground_q <= 1'b0;
            end else if (jump_req_q && !bus.coll[1]) begin
              state_q     <= ST_RISE;
              rise_cnt_q  <= 7'd0;
              on_ground_q <= 1'b0;
            end
          end
          ST_RISE: begin
            // Floor flag is irrelevant while rising; only head bump or height end it.
            if (bus.coll[1] || (y_q == 9'd0)) begin
              state_q <= ST_FALL;
            end else begin
              y_q        <= y_q - 9'd1;
              rise_cnt_q <= rise_cnt_q + 7'd1;
              if ((rise_cnt_q + 7'd1) == JUMP_H)
                state_q <= ST_FALL;
            end
          end
          ST_FALL: begin
            if (bus.coll[0]) begin
              state_q     <= ST_STAND;
              on_ground_q <= 1'b1;
            end else if (y_q >= Y_MAX) begin
              y_q         <= Y_MAX;
              state_q     <= ST_STAND;
              on_ground_q <= 1'b1;
            end else begin
              y_q <= y_q + 9'd1;
            end
          end
          default: begin
            state_q     <= ST_FALL;
            on_ground_q <= 1'b0;
          end
        endcase
      end else if (jump_rise) begin
        jump_req_q <= 1'b1;
      end
    end
  end

  assign bus.x_blue    = x_q;
  assign bus.y_blue    = y_q;
  assign bus.v_state   = state_q;
  assign bus.on_ground = on_ground_q;

endmodule
